mdu_ctrl: RTL and testbench

Multi-cycle multiply/divide unit controller for the pipelined MIPS core. It sits in the E stage beside the ALU, accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from the E-stage decode, and holds HI/LO. It models mult latency and div latency with a busy counter, and raises a stall request so D-stage MDU instructions wait until the unit is free.

---
 rtl/mdu_ctrl_pkg.sv | 40 ++++
 rtl/mdu_div_core.sv | 26 ++
 rtl/mdu_ctrl.sv | 131 +++++++++++++
 tb/tb_mdu_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and decode helpers for the MDU controller.
// Accumulate opcodes are only decoded as multi-cycle when MDU_MADD_EN is defined.
package mdu_ctrl_pkg;

  // Opcodes carry an _OP_ infix so they do not collide with the state names.
  localparam logic [3:0] MDU_OP_MULT  = 4'd0;
  localparam logic [3:0] MDU_OP_MULTU = 4'd1;
  localparam logic [3:0] MDU_OP_DIV   = 4'd2;
  localparam logic [3:0] MDU_OP_DIVU  = 4'd3;
  localparam logic [3:0] MDU_OP_MTHI  = 4'd4;
  localparam logic [3:0] MDU_OP_MTLO  = 4'd5;
  localparam logic [3:0] MDU_OP_MFHI  = 4'd6;
  localparam logic [3:0] MDU_OP_MFLO  = 4'd7;
  localparam logic [3:0] MDU_OP_MADD  = 4'd8;
  localparam logic [3:0] MDU_OP_MADDU = 4'd9;
  localparam logic [3:0] MDU_OP_MSUB  = 4'd10;
  localparam logic [3:0] MDU_OP_MSUBU = 4'd11;
  localparam logic [3:0] MDU_OP_NONE  = 4'd15;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_MULT = 2'd1,
    MDU_DIV  = 2'd2
  } mdu_state_e;

  function automatic logic mdu_is_mul(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return (op == MDU_OP_MULT) || (op == MDU_OP_MULTU) ||
           (op == MDU_OP_MADD) || (op == MDU_OP_MADDU) ||
           (op == MDU_OP_MSUB) || (op == MDU_OP_MSUBU);
`else
    return (op == MDU_OP_MULT) || (op == MDU_OP_MULTU);
`endif
  endfunction

  function automatic logic mdu_is_div(input logic [3:0] op);
    return (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Combinational 32-bit divider: quotient truncates toward zero, remainder
// follows the dividend's sign; flags a zero divisor.
module mdu_div_core (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        sgn_i,
  output logic [31:0] quo_o,
  output logic [31:0] rem_o,
  output logic        dz_o
);

  logic        neg_a, neg_b;
  logic [31:0] ua, ub, uq, ur;

  assign dz_o  = (b_i == 32'd0);
  assign neg_a = sgn_i & a_i[31];
  assign neg_b = sgn_i & b_i[31];
  assign ua    = neg_a ? (32'd0 - a_i) : a_i;
  // Divisor forced to 1 on zero so the divider never sees x/0.
  assign ub    = dz_o ? 32'd1 : (neg_b ? (32'd0 - b_i) : b_i);
  assign uq    = ua / ub;
  assign ur    = ua % ub;
  assign quo_o = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
  assign rem_o = neg_a ? (32'd0 - ur) : ur;

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: HI/LO registers, mult/div latency counter and D-stage stall.
// Define MDU_MADD_EN to add madd/maddu/msub/msubu accumulate operations.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] result
);

  mdu_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

  logic        mul_sgn, ext_a, ext_b;
  logic [63:0] prod;
  logic [31:0] quo, rem;
  logic        dz;

`ifdef MDU_MADD_EN
  assign mul_sgn = (op == MDU_OP_MULT) || (op == MDU_OP_MADD) || (op == MDU_OP_MSUB);
`else
  assign mul_sgn = (op == MDU_OP_MULT);
`endif
  // One 64x64 multiplier serves both signednesses via operand extension.
  assign ext_a = mul_sgn & A[31];
  assign ext_b = mul_sgn & B[31];
  assign prod  = {{32{ext_a}}, A} * {{32{ext_b}}, B};

  mdu_div_core u_div (
    .a_i   (A),
    .b_i   (B),
    .sgn_i (op == MDU_OP_DIV),
    .quo_o (quo),
    .rem_o (rem),
    .dz_o  (dz)
  );

`ifdef MDU_MADD_EN
  logic [63:0] acc;
  logic        acc_sub;
  assign acc_sub = (op == MDU_OP_MSUB) || (op == MDU_OP_MSUBU);
  assign acc     = acc_sub ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    unique case (state_q)
      MDU_IDLE: begin
        if (start) begin
          case (op)
            MDU_OP_MULT, MDU_OP_MULTU: begin
              {pend_hi_d, pend_lo_d} = prod;
              cnt_d   = 4'(MULT_CYCLES);
              state_d = MDU_MULT;
            end
`ifdef MDU_MADD_EN
            MDU_OP_MADD, MDU_OP_MADDU, MDU_OP_MSUB, MDU_OP_MSUBU: begin
              {pend_hi_d, pend_lo_d} = acc;
              cnt_d   = 4'(MULT_CYCLES);
              state_d = MDU_MULT;
            end
`endif
            MDU_OP_DIV, MDU_OP_DIVU: begin
              // Zero divisor recommits the current HI/LO, leaving them unchanged.
              {pend_hi_d, pend_lo_d} = dz ? {hi_q, lo_q} : {rem, quo};
              cnt_d   = 4'(DIV_CYCLES);
              state_d = MDU_DIV;
            end
            MDU_OP_MTHI: hi_d = A;
            MDU_OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      MDU_MULT, MDU_DIV: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          state_d = MDU_IDLE;
        end
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= MDU_IDLE;
      cnt_q     <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign busy   = (state_q != MDU_IDLE);
  assign stall  = d_md_use & (busy | (start & (mdu_is_mul(op) | mdu_is_div(op))));
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign result = (op == MDU_OP_MFHI) ? hi_q :
                  (op == MDU_OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl with hand-computed HI/LO results.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, d_md_use;
  logic [3:0]  op;
  logic [31:0] A, B;
  logic        busy, stall;
  logic [31:0] hi, lo, result;

  int n_chk = 0;
  int n_err = 0;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .A        (A),
    .B        (B),
    .d_md_use (d_md_use),
    .busy     (busy),
    .stall    (stall),
    .hi       (hi),
    .lo       (lo),
    .result   (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle; returns at the negedge of the first cycle after the edge.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0; op = MDU_OP_NONE;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run(input string tag, input logic [3:0] o, input logic [31:0] a,
                     input logic [31:0] b, input int cyc, input logic [31:0] eh,
                     input logic [31:0] el);
    int n;
    issue(o, a, b);
    wait_idle(n);
    check({tag, "_cycles"}, 32'(n), 32'(cyc));
    check({tag, "_hi"}, hi, eh);
    check({tag, "_lo"}, lo, el);
  endtask

  initial begin
    int n, ns;
    reset = 1'b1; start = 1'b0; op = MDU_OP_NONE; A = '0; B = '0; d_md_use = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b0;

    run("mult",  MDU_OP_MULT,  32'hFFFFFFFF, 32'd2, 5, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run("multu", MDU_OP_MULTU, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE);
    run("div",   MDU_OP_DIV,   32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run("divu",  MDU_OP_DIVU,  32'hFFFFFFF9, 32'd2, 10, 32'h00000001, 32'h7FFFFFFC);
    run("divov", MDU_OP_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000);

    issue(MDU_OP_MTHI, 32'h12, 32'd0);
    check("mthi_busy", 32'(busy), 32'd0);
    check("mthi_hi", hi, 32'h12);
    issue(MDU_OP_MTLO, 32'h34, 32'd0);
    check("mtlo_busy", 32'(busy), 32'd0);
    check("mtlo_lo", lo, 32'h34);
    run("divz", MDU_OP_DIV, 32'd77, 32'd0, 10, 32'h12, 32'h34);

    @(negedge clk);
    start = 1'b1; op = MDU_OP_MFLO; #1;
    check("mflo_res", result, 32'h34);
    op = MDU_OP_MFHI; #1;
    check("mfhi_res", result, 32'h12);
    op = MDU_OP_NONE; #1;
    check("none_res", result, 32'h0);
    start = 1'b0;

    // Stall window, with an mthi pulsed mid-operation that must be ignored.
    @(negedge clk);
    d_md_use = 1'b1; #1;
    check("stall_idle", 32'(stall), 32'd0);
    start = 1'b1; op = MDU_OP_MULT; A = 32'd3; B = 32'd4; #1;
    check("stall_start", 32'(stall), 32'd1);
    @(negedge clk);
    start = 1'b0; op = MDU_OP_NONE;
    n = 0; ns = 0;
    while (busy && n < 40) begin
      if (stall) ns++;
      n++;
      if (n == 2) begin start = 1'b1; op = MDU_OP_MTHI; A = 32'hDEAD; end
      else begin start = 1'b0; op = MDU_OP_NONE; end
      @(negedge clk);
    end
    start = 1'b0; op = MDU_OP_NONE;
    check("stall_cycles", 32'(n), 32'd5);
    check("stall_busy_cnt", 32'(ns), 32'd5);
    check("stall_after", 32'(stall), 32'd0);
    check("ign_hi", hi, 32'd0);
    check("ign_lo", lo, 32'd12);
    d_md_use = 1'b0;

    // Reset in the third busy cycle of a div aborts it.
    issue(MDU_OP_DIV, 32'd100, 32'd7);
    repeat (2) @(negedge clk);
    check("abort_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_late_busy", 32'(busy), 32'd0);
    check("abort_late_hi", hi, 32'd0);
    check("abort_late_lo", lo, 32'd0);

    issue(MDU_OP_MTHI, 32'd0, 32'd0);
    issue(MDU_OP_MTLO, 32'hFFFFFFFF, 32'd0);
`ifdef MDU_MADD_EN
    run("madd", MDU_OP_MADD, 32'd1, 32'd1, 5, 32'd1, 32'd0);
`else
    run("madd", MDU_OP_MADD, 32'd1, 32'd1, 0, 32'd0, 32'hFFFFFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
